encoder4_2: RTL and testbench

ENCODER4_2 -- requirements
Module: encoder4_2

---
 rtl/encoder_pkg.sv | 20 ++
 rtl/encoder4_2_prio4.sv | 38 +++
 rtl/encoder4_2.sv | 80 ++++++++
 tb/tb_encoder4_2.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared types and constants for the 4-to-2 draining encoder.
// Defines the FSM state type and a single-bit-set helper.
package encoder_pkg;

  localparam int IN_W   = 4;
  localparam int CODE_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  function automatic logic single_hot(
    input logic [IN_W-1:0] v
  );
    return (v != '0) &&
           ((v & (v - 4'd1)) == '0);
  endfunction

endpackage

// File: rtl/encoder4_2_prio4.sv
// Highest-set-bit picker: binary index plus
// a one-hot mask selecting that bit.
module prio4
  import encoder_pkg::*;
(
  input  logic [IN_W-1:0]   req_i,
  output logic [CODE_W-1:0] idx_o,
  output logic [IN_W-1:0]   mask_o
);

  always_comb begin
    idx_o  = '0;
    mask_o = '0;
    priority case (1'b1)
      req_i[3]: begin
        idx_o  = 2'b11;
        mask_o = 4'b1000;
      end
      req_i[2]: begin
        idx_o  = 2'b10;
        mask_o = 4'b0100;
      end
      req_i[1]: begin
        idx_o  = 2'b01;
        mask_o = 4'b0010;
      end
      req_i[0]: begin
        idx_o  = 2'b00;
        mask_o = 4'b0001;
      end
      default: begin
        idx_o  = '0;
        mask_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/encoder4_2.sv
// Captures a request vector and drains it as binary
// codes, highest line first, over a valid/ready port.
module encoder4_2
  import encoder_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              en,
  input  logic [IN_W-1:0]   in,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out,
  output logic              valid,
  output logic              last,
  output logic              busy,
  output logic              zero
);

  state_e            state_q, state_d;
  logic [IN_W-1:0]   pend_q, pend_d;
  logic              zero_q, zero_d;

  logic [CODE_W-1:0] idx;
  logic [IN_W-1:0]   mask;
  logic              emit;
  logic              hs;
  logic              fin;

  prio4 u_prio (
    .req_i  (pend_q),
    .idx_o  (idx),
    .mask_o (mask)
  );

  assign emit = (state_q == EMIT);
  assign fin  = emit && single_hot(pend_q);
  assign hs   = emit && out_ready;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && (in != '0)) begin
          pend_d  = in;
          state_d = EMIT;
        end else if (en) begin
          zero_d = 1'b1;
        end
      end
      EMIT: begin
        if (hs) begin
          pend_d = pend_q & ~mask;
          if (fin) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zero_q  <= zero_d;
    end
  end

  // Outputs decode registered state only.
  assign out   = emit ? idx : '0;
  assign valid = emit;
  assign busy  = emit;
  assign last  = fin;
  assign zero  = zero_q;

endmodule

// File: tb/tb_encoder4_2.sv
// Bench for encoder4_2: directed scenarios plus
// random traffic against a bit-vector reference model.
module tb_encoder4_2;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       en;
  logic [3:0] in;
  logic       out_ready;
  logic [1:0] out;
  logic       valid, last, busy, zero;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit         m_busy;
  bit   [3:0] m_pend;
  bit         m_zero;

  encoder4_2 dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (en),
    .in        (in),
    .out_ready (out_ready),
    .out       (out),
    .valid     (valid),
    .last      (last),
    .busy      (busy),
    .zero      (zero)
  );

  always #5 clock = ~clock;

  // {out, valid, last, busy, zero}
  function automatic logic [5:0] obs();
    return {out, valid, last, busy, zero};
  endfunction

  function automatic int hi_bit(bit [3:0] v);
    for (int i = 3; i >= 0; i--)
      if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [5:0] exp_obs();
    logic [1:0] o;
    logic       l;
    o = m_busy ? 2'(hi_bit(m_pend)) : 2'b00;
    l = m_busy && ($countones(m_pend) == 1);
    return {o, m_busy, l, m_busy, m_zero};
  endfunction

  function automatic void model_reset();
    m_busy = 0;
    m_pend = '0;
    m_zero = 0;
  endfunction

  function automatic void model_edge();
    if (!reset_n) begin
      model_reset();
    end else if (m_busy) begin
      m_zero = 0;
      if (out_ready) begin
        m_pend[hi_bit(m_pend)] = 1'b0;
        if (m_pend == 0) m_busy = 0;
      end
    end else begin
      m_zero = en && (in == 0);
      if (en && in != 0) begin
        m_pend = in;
        m_busy = 1;
      end
    end
  endfunction

  task automatic drive(bit e, bit [3:0] v, bit r);
    en        = e;
    in        = v;
    out_ready = r;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic test_reset();
    drive(1, 4'b1111, 1);
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== 6'b0) begin
      errors++;
      $display("FAIL reset_async got=%b want=%b",
               obs(), 6'b0);
    end
    repeat (2) cycle();
    checks++;
    if (obs() !== 6'b0) begin
      errors++;
      $display("FAIL reset_hold got=%b want=%b",
               obs(), 6'b0);
    end
    drive(0, 4'b0, 0);
    reset_n = 1'b1;
    cycle();
    checks++;
    if (obs() !== 6'b0) begin
      errors++;
      $display("FAIL reset_release got=%b want=%b",
               obs(), 6'b0);
    end
  endtask

  task automatic test_drain_1010();
    logic [5:0] want [3];
    want[0] = {2'b11, 1'b1, 1'b0, 1'b1, 1'b0};
    want[1] = {2'b01, 1'b1, 1'b1, 1'b1, 1'b0};
    want[2] = 6'b0;
    drive(1, 4'b1010, 1);
    cycle();
    drive(0, 4'b0, 1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs() !== want[i]) begin
        errors++;
        $display("FAIL drain1010[%0d] got=%b want=%b",
                 i, obs(), want[i]);
      end
      cycle();
    end
  endtask

  task automatic test_stall_1111();
    logic [5:0] want [8];
    for (int i = 0; i < 3; i++)
      want[i] = {2'b11, 1'b1, 1'b0, 1'b1, 1'b0};
    want[3] = {2'b11, 1'b1, 1'b0, 1'b1, 1'b0};
    want[4] = {2'b10, 1'b1, 1'b0, 1'b1, 1'b0};
    want[5] = {2'b01, 1'b1, 1'b0, 1'b1, 1'b0};
    want[6] = {2'b00, 1'b1, 1'b1, 1'b1, 1'b0};
    want[7] = 6'b0;
    drive(1, 4'b1111, 0);
    cycle();
    drive(0, 4'b0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) out_ready = 1'b1;
      checks++;
      if (obs() !== want[i]) begin
        errors++;
        $display("FAIL stall1111[%0d] got=%b want=%b",
                 i, obs(), want[i]);
      end
      cycle();
    end
  endtask

  task automatic test_zero();
    drive(1, 4'b0000, 0);
    cycle();
    drive(0, 4'b0, 0);
    checks++;
    if (obs() !== 6'b000001) begin
      errors++;
      $display("FAIL zero_pulse got=%b want=%b",
               obs(), 6'b000001);
    end
    cycle();
    checks++;
    if (obs() !== 6'b0) begin
      errors++;
      $display("FAIL zero_clear got=%b want=%b",
               obs(), 6'b0);
    end
  endtask

  task automatic test_drop_busy();
    logic [5:0] w;
    w = {2'b10, 1'b1, 1'b1, 1'b1, 1'b0};
    drive(1, 4'b0100, 0);
    cycle();
    drive(1, 4'b0001, 0);
    checks++;
    if (obs() !== w) begin
      errors++;
      $display("FAIL drop_first got=%b want=%b",
               obs(), w);
    end
    cycle();
    checks++;
    if (obs() !== w) begin
      errors++;
      $display("FAIL drop_hold got=%b want=%b",
               obs(), w);
    end
    out_ready = 1'b1;
    cycle();
    drive(0, 4'b0, 1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs() !== 6'b0) begin
        errors++;
        $display("FAIL drop_after[%0d] got=%b want=%b",
                 i, obs(), 6'b0);
      end
      cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] w;
    drive(1, 4'b1001, 1);
    cycle();
    drive(0, 4'b0, 1);
    w = {2'b11, 1'b1, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs() !== w) begin
      errors++;
      $display("FAIL rstmid_first got=%b want=%b",
               obs(), w);
    end
    cycle();
    w = {2'b00, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs() !== w) begin
      errors++;
      $display("FAIL rstmid_second got=%b want=%b",
               obs(), w);
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== 6'b0) begin
      errors++;
      $display("FAIL rstmid_async got=%b want=%b",
               obs(), 6'b0);
    end
    cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (obs() !== 6'b0) begin
        errors++;
        $display("FAIL rstmid_post[%0d] got=%b want=%b",
                 i, obs(), 6'b0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] w;
    drive(1, 4'b0001, 1);
    cycle();
    for (int i = 0; i < 4; i++) begin
      w = {2'(i), 1'b1, 1'b1, 1'b1, 1'b0};
      checks++;
      if (obs() !== w) begin
        errors++;
        $display("FAIL b2b_code[%0d] got=%b want=%b",
                 i, obs(), w);
      end
      if (i < 3) drive(1, 4'(1 << (i + 1)), 1);
      else       drive(0, 4'b0, 1);
      cycle();
      checks++;
      if (obs() !== 6'b0) begin
        errors++;
        $display("FAIL b2b_idle[%0d] got=%b want=%b",
                 i, obs(), 6'b0);
      end
      cycle();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      checks++;
      if (obs() !== exp_obs()) begin
        errors++;
        $display("FAIL random[%0d] got=%b want=%b",
                 n, obs(), exp_obs());
      end
      drive($urandom_range(0, 2) != 0,
            4'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0);
      cycle();
    end
  endtask

  initial begin
    reset_n = 1'b1;
    drive(0, 4'b0, 0);
    model_reset();
    @(negedge clock);
    test_reset();
    test_drain_1010();
    test_stall_1111();
    test_zero();
    test_drop_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
